fifo_drain_ctrl: RTL and testbench
==================================

FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, meaning the FIFO read-data and TX-data width.
REQ-002 The module SHALL have parameter CNT_WIDTH, default 8, meaning the width of the sent-word counter.
REQ-003 The module SHALL have port rclk, input, 1 bit: the single clock.
REQ-004 The module SHALL have port rrst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The module SHALL have port en, input, 1 bit: drain enable.
REQ-006 The module SHALL have port rempty, input, 1 bit: FIFO read-side empty flag.
REQ-007 The module SHALL have port rdata, input, DATA_WIDTH bits: FIFO word currently addressed by raddr (combinational read).
REQ-008 The module SHALL have port tx_busy, input, 1 bit: downstream serializer busy.
REQ-009 The module SHALL have port rinc, output, 1 bit: FIFO pop strobe.
REQ-010 The module SHALL have port tx_data, output, DATA_WIDTH bits: word presented to the serializer.
REQ-011 The module SHALL have port tx_valid, output, 1 bit: tx_data valid.
REQ-012 The module SHALL have port sent_cnt, output, CNT_WIDTH bits: count of completed transfers.
REQ-013 The module SHALL have port idle, output, 1 bit: high only in state IDLE.

Function
REQ-014 The FSM SHALL have four states: IDLE, LOAD, WAIT_ACK, WAIT_DONE.
REQ-015 IDLE -> LOAD SHALL occur when en=1 and rempty=0, sampled at a rclk edge.
REQ-016 In LOAD, rdata SHALL be registered into tx_data, rinc SHALL be 1 for exactly this one cycle, and the next state SHALL be WAIT_ACK.
REQ-017 tx_valid SHALL be registered and SHALL be high throughout WAIT_ACK, low in all other states.
REQ-018 WAIT_ACK -> WAIT_DONE SHALL occur on the first edge where tx_busy=1; tx_data SHALL be held stable until that edge.
REQ-019 WAIT_DONE -> IDLE SHALL occur on the first edge where tx_busy=0; sent_cnt SHALL increment by 1 on that transition, wrapping from all-ones to 0.
REQ-020 rinc SHALL never assert when rempty=1 at the LOAD-entry edge.
REQ-021 Two rinc pulses SHALL be separated by at least 3 rclk cycles, absorbing the 2-cycle pointer/empty update latency of the FIFO read side.
REQ-022 Deasserting en SHALL NOT abort a transfer in progress; it only blocks IDLE -> LOAD.
REQ-023 If tx_busy is already 1 on entry to WAIT_ACK, the FSM SHALL move to WAIT_DONE on the next edge.
REQ-024 Back-to-back draining SHALL resume from IDLE without extra gap beyond REQ-021 when rempty=0 and en=1.
REQ-025 idle SHALL be a combinational decode of state==IDLE.

Reset
REQ-026 On rrst_n=0, asynchronously: state=IDLE, rinc=0, tx_valid=0, tx_data=0, sent_cnt=0.
REQ-027 Reset asserted mid-transfer SHALL discard the transfer without incrementing sent_cnt; the popped word is lost.
REQ-028 After rrst_n deasserts, the first rinc SHALL occur no earlier than the second rclk edge.

Structure
REQ-029 State encodings (2-bit IDLE=0, LOAD=1, WAIT_ACK=2, WAIT_DONE=3) and the default widths SHALL live in the shared package fifo_drain_pkg.
REQ-030 The block SHALL be a single module with no sub-modules, using a registered state and a combinational next-state decode.

Verification
REQ-031 FIFO holding 0xA5, en=1, tx_busy rising 2 cycles after tx_valid and falling 10 cycles later -> one rinc pulse, tx_data=0xA5, sent_cnt=1, idle=1.
REQ-032 Three words 0x01, 0x02, 0x03 with a busy-handshake model -> tx_data sequence 0x01, 0x02, 0x03, rinc gaps of at least 3 cycles, sent_cnt=3.
REQ-033 rempty=1 with en=1 for 20 cycles -> rinc=0, tx_valid=0, state stays IDLE.
REQ-034 en dropped during WAIT_ACK -> transfer completes, sent_cnt increments, no further LOAD while en=0.
REQ-035 rrst_n pulsed low during WAIT_DONE -> all outputs 0 immediately, sent_cnt unchanged from 0 after reset.
REQ-036 sent_cnt preloaded by 255 transfers, then one more transfer -> sent_cnt wraps to 0.

Source files
------------

// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg: shared types and defaults for the FIFO drain controller.
// State encodings and default widths used by the drain block and its bench.
package fifo_drain_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } drain_state_e;

endpackage

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: pops FIFO words and hands them to a serializer.
// One word in flight; busy-high then busy-low completes a transfer.
module fifo_drain_ctrl
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int CNT_WIDTH  = CNT_W_DEF
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  en,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  tx_busy,
  output logic                  rinc,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic [CNT_WIDTH-1:0]  sent_cnt,
  output logic                  idle
);

  drain_state_e state_q;
  drain_state_e state_d;
  logic         armed_q;
  logic         done;

  assign done = (state_q == WAIT_DONE) && !tx_busy;
  assign idle = (state_q == IDLE);

  // Next-state decode; armed_q keeps the first edge after reset from loading.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (armed_q && en && !rempty)
          state_d = LOAD;
      end
      LOAD: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy)
          state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy)
          state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, registered strobes, captured word and completed-transfer count.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q  <= IDLE;
      armed_q  <= 1'b0;
      rinc     <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      sent_cnt <= '0;
    end else begin
      state_q  <= state_d;
      armed_q  <= 1'b1;
      rinc     <= (state_d == LOAD);
      tx_valid <= (state_d == WAIT_ACK);
      if (state_q == LOAD)
        tx_data <= rdata;
      if (done)
        sent_cnt <= sent_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb_fifo_drain_ctrl: directed bench with FIFO model, busy model
// and a scoreboard of expected tx words.
module tb_fifo_drain_ctrl;
  import fifo_drain_pkg::*;

  localparam int DW = 8;
  localparam int CW = 8;

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b0;
  logic          en = 1'b0;
  logic          rempty = 1'b1;
  logic [DW-1:0] rdata = '0;
  logic          tx_busy = 1'b0;
  logic          rinc;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic [CW-1:0] sent_cnt;
  logic          idle;

  always #5 rclk = ~rclk;

  fifo_drain_ctrl #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .en      (en),
    .rempty  (rempty),
    .rdata   (rdata),
    .tx_busy (tx_busy),
    .rinc    (rinc),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .sent_cnt(sent_cnt),
    .idle    (idle)
  );

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  int  cyc = 0;
  int  last_rinc = -100;
  int  rinc_cnt = 0;
  int  tv_cycles = 0;
  bit  auto_busy = 1'b0;
  int  b_delay = 2;
  int  b_len = 10;
  int  b_wait = 0;
  int  b_left = 0;
  bit  prev_tv = 1'b0;
  logic [DW-1:0] held = '0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? '0 : fifo_q[0];
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    refresh();
  endtask

  task automatic tick();
    bit rs;
    bit tv;
    logic [DW-1:0] e;
    @(negedge rclk);
    rs = rinc;
    tv = tx_valid;
    if (tv && !prev_tv) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tx_data", 32'(tx_data), 32'(e));
      end
    end
    if (tv && prev_tv)
      chk("tx_hold", 32'(tx_data), 32'(held));
    if (tv) begin
      held = tx_data;
      tv_cycles++;
    end
    prev_tv = tv;
    if (rs) begin
      chk("rinc_gap", 32'((cyc - last_rinc) >= 4), 32'd1);
      chk("rinc_nonempty", 32'(rempty), 32'd0);
      last_rinc = cyc;
      rinc_cnt++;
    end
    @(posedge rclk);
    cyc++;
    if (rs && fifo_q.size() > 0)
      void'(fifo_q.pop_front());
    #1;
    if (auto_busy) begin
      if (tx_busy) begin
        b_left--;
        if (b_left <= 0) begin
          tx_busy = 1'b0;
          b_wait = 0;
        end
      end else if (tv) begin
        b_wait++;
        if (b_wait >= b_delay) begin
          tx_busy = 1'b1;
          b_left = b_len;
          b_wait = 0;
        end
      end
    end
    refresh();
  endtask

  task automatic wait_cnt(input logic [CW-1:0] target,
                          input int budget,
                          input string tag);
    int n;
    n = 0;
    while (sent_cnt !== target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(sent_cnt), 32'(target));
  endtask

  task automatic wait_tv(input int budget, input string tag);
    int n;
    n = 0;
    while (tx_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(tx_valid), 32'd1);
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge rclk);
    #1;
    chk("rst_rinc", 32'(rinc), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_sent_cnt", 32'(sent_cnt), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    rrst_n = 1'b1;
    repeat (3) tick();

    // single word, busy 2 cycles after valid, 10 cycles long
    auto_busy = 1'b1;
    b_delay = 2;
    b_len = 10;
    tv_cycles = 0;
    en = 1'b1;
    push(8'hA5);
    wait_cnt(8'd1, 60, "t1_sent_cnt");
    chk("t1_rinc_cnt", 32'(rinc_cnt), 32'd1);
    chk("t1_tx_data", 32'(tx_data), 32'hA5);
    chk("t1_idle", 32'(idle), 32'd1);
    chk("t1_tv_cycles", 32'(tv_cycles), 32'd3);

    // three words back to back
    b_delay = 1;
    b_len = 3;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    wait_cnt(8'd4, 200, "t2_sent_cnt");
    chk("t2_rinc_cnt", 32'(rinc_cnt), 32'd4);
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t2_fifo_empty", 32'(fifo_q.size()), 32'd0);

    // empty FIFO with enable held
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t3_rinc", 32'(rinc), 32'd0);
      chk("t3_tx_valid", 32'(tx_valid), 32'd0);
      chk("t3_idle", 32'(idle), 32'd1);
    end

    // enable dropped during WAIT_ACK
    b_delay = 3;
    b_len = 4;
    push(8'h5C);
    push(8'h77);
    wait_tv(20, "t4_tv_seen");
    en = 1'b0;
    wait_cnt(8'd5, 60, "t4_sent_cnt");
    repeat (10) tick();
    chk("t4_rinc_cnt", 32'(rinc_cnt), 32'd5);
    chk("t4_idle", 32'(idle), 32'd1);
    chk("t4_fifo_left", 32'(fifo_q.size()), 32'd1);

    // busy already high on entry to WAIT_ACK
    auto_busy = 1'b0;
    tx_busy = 1'b1;
    tv_cycles = 0;
    en = 1'b1;
    wait_tv(20, "t5_tv_seen");
    tick();
    chk("t5_tx_valid", 32'(tx_valid), 32'd0);
    chk("t5_idle", 32'(idle), 32'd0);
    chk("t5_tv_cycles", 32'(tv_cycles), 32'd1);
    tx_busy = 1'b0;
    wait_cnt(8'd6, 10, "t5_sent_cnt");
    chk("t5_rinc_cnt", 32'(rinc_cnt), 32'd6);

    // reset pulse during WAIT_DONE
    push(8'h3C);
    wait_tv(20, "t6_tv_seen");
    tx_busy = 1'b1;
    tick();
    tick();
    chk("t6_pre_idle", 32'(idle), 32'd0);
    chk("t6_pre_tx_valid", 32'(tx_valid), 32'd0);
    rrst_n = 1'b0;
    #2;
    chk("t6_rinc", 32'(rinc), 32'd0);
    chk("t6_tx_valid", 32'(tx_valid), 32'd0);
    chk("t6_tx_data", 32'(tx_data), 32'd0);
    chk("t6_sent_cnt", 32'(sent_cnt), 32'd0);
    chk("t6_idle", 32'(idle), 32'd1);
    tx_busy = 1'b0;
    prev_tv = 1'b0;
    last_rinc = -100;
    rinc_cnt = 0;
    push(8'h96);
    tick();
    tick();
    rrst_n = 1'b1;
    tick();
    chk("t6_first_edge_rinc", 32'(rinc), 32'd0);
    chk("t6_post_sent_cnt", 32'(sent_cnt), 32'd0);
    auto_busy = 1'b1;
    b_delay = 0;
    b_len = 1;
    wait_cnt(8'd1, 30, "t6_resume_cnt");

    // counter wrap after 256 transfers
    for (int i = 0; i < 254; i++)
      push(DW'($urandom_range(0, 255)));
    wait_cnt(8'd255, 2540, "t7_cnt_255");
    push(8'hE7);
    wait_cnt(8'd0, 30, "t7_cnt_wrap");
    chk("t7_rinc_cnt", 32'(rinc_cnt), 32'd256);
    chk("t7_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t7_idle", 32'(idle), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
